// File: rtl/preempt_controller.sv
`default_nettype none
// ============================================================================
//  Module   : preempt_controller
//  Purpose  : Time-slice preemption controller. Counts retired user
//             instructions against a runtime-loadable quantum. On quantum
//             expiry or process end it raises a registered one-cycle
//             switch-to-OS pulse, redirects the fetch PC to the OS vector,
//             saves the interrupted PC and cause, and then stays frozen
//             until the OS returns.
//  Ports    : clock        - system clock, all state on rising edge
//             reset        - synchronous, active-high
//             instr_retire - one user instruction completed this cycle
//             end_proc     - running process finished (level)
//             os_return    - OS finished switch (one-cycle pulse)
//             quantum_we   - load quantum_in into the quantum register
//             quantum_in   - new quantum, 0 disables preemption
//             pc_curr      - PC the core would fetch next
//             pc_new       - PC to fetch (OS_VECTOR during the switch pulse)
//             enable_so    - one-cycle switch-to-OS pulse
//             in_so        - high while the OS owns the core
//             saved_pc     - pc_curr captured at the switch decision
//             cause        - bit0 quantum expiry, bit1 end_proc
//             count        - current instruction counter
//  Revision : 1.0 - initial release
// ============================================================================
module preempt_controller #(
  parameter int PC_WIDTH        = 32,
  parameter int CNT_WIDTH       = 8,
  parameter int DEFAULT_QUANTUM = 20,
  parameter int OS_VECTOR       = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 instr_retire,
  input  logic                 end_proc,
  input  logic                 os_return,
  input  logic                 quantum_we,
  input  logic [CNT_WIDTH-1:0] quantum_in,
  input  logic [PC_WIDTH-1:0]  pc_curr,
  output logic [PC_WIDTH-1:0]  pc_new,
  output logic                 enable_so,
  output logic                 in_so,
  output logic [PC_WIDTH-1:0]  saved_pc,
  output logic [1:0]           cause,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] c_quantum_rst = CNT_WIDTH'(DEFAULT_QUANTUM);
  localparam logic [PC_WIDTH-1:0]  c_os_vector   = PC_WIDTH'(OS_VECTOR);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max     = '1;

  typedef enum logic [1:0] {
    USER   = 2'd0,
    SWITCH = 2'd1,
    OS     = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   r_quantum;
  logic [PC_WIDTH-1:0]    r_saved_pc;
  logic [1:0]             r_cause;
  logic                   r_enable_so;

  logic [CNT_WIDTH:0]     w_count_next_ext;
  logic                   w_expiry;
  logic                   w_switch;

  // The retire of the current cycle counts toward expiry, so the pulse
  // follows the quantum-th retire directly. One extra bit keeps the sum
  // from wrapping at the all-ones count.
  assign w_count_next_ext = {1'b0, r_count} + (CNT_WIDTH + 1)'(instr_retire);
  assign w_expiry         = (r_quantum != '0) &&
                            (w_count_next_ext >= {1'b0, r_quantum});
  assign w_switch         = (r_state == USER) && (w_expiry || end_proc);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= USER;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and outputs
  always_comb begin
    w_next_state = r_state;
    pc_new       = pc_curr;
    in_so        = 1'b0;
    case (r_state)
      USER:    if (w_switch) w_next_state = SWITCH;
      SWITCH:  w_next_state = OS;
      OS:      if (os_return) w_next_state = USER;
      default: w_next_state = USER;
    endcase
    if (r_state != USER) in_so = 1'b1;
    if (r_enable_so) pc_new = c_os_vector;
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= '0;
      r_quantum   <= c_quantum_rst;
      r_saved_pc  <= '0;
      r_cause     <= 2'b00;
      r_enable_so <= 1'b0;
    end else begin
      r_enable_so <= 1'b0;
      // The comparison this cycle already used the old quantum.
      if (quantum_we) r_quantum <= quantum_in;
      case (r_state)
        USER: begin
          if (instr_retire && (r_count != c_cnt_max)) begin
            r_count <= r_count + CNT_WIDTH'(1);
          end
          if (w_switch) begin
            r_saved_pc  <= pc_curr;
            r_cause     <= {end_proc, w_expiry};
            r_enable_so <= 1'b1;
          end
        end
        OS: begin
          if (os_return) begin
            r_count <= '0;
            r_cause <= 2'b00;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign enable_so = r_enable_so;
  assign saved_pc  = r_saved_pc;
  assign cause     = r_cause;
  assign count     = r_count;

endmodule
`default_nettype wire
